// File: rtl/neuron_mac.sv
// Multiply-accumulate front end of one neuron: sums N_INPUTS x*w terms, scales by 1/16 and clamps to 0..255.
// Optional feature macro: NEURON_MAC_BIAS_EN adds a signed bias input preloaded into the accumulator.
module neuron_mac #(
   parameter int N_INPUTS = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       x_valid,
   output logic       x_ready,
   input  logic [7:0] x,
   input  logic [7:0] w,
   output logic [7:0] z,
   output logic       z_valid,
   output logic       sat,
   output logic       busy
`ifdef NEURON_MAC_BIAS_EN
   ,
   input  logic [7:0] bias
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      SCALE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [4:0] LAST_TERM = 5'(N_INPUTS - 1);

   state_t              state, state_next;
   logic [4:0]          term_cnt;
   logic signed [21:0]  acc;
   logic signed [21:0]  acc_init;
   logic signed [16:0]  product;
   logic signed [21:0]  scaled;
   logic                accept;

`ifdef NEURON_MAC_BIAS_EN
   // Bias is pre-shifted so that it lands in z units after the final >>> 4.
   assign acc_init = {{10{bias[7]}}, bias, 4'b0000};
`else
   assign acc_init = '0;
`endif

   assign product = $signed({1'b0, x}) * $signed(w);
   assign scaled  = acc >>> 4;
   assign accept  = x_valid && x_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      x_ready    = 1'b0;
      z_valid    = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = ACC;
         end
         ACC: begin
            x_ready = 1'b1;
            if (x_valid && term_cnt == LAST_TERM) state_next = SCALE;
         end
         SCALE: state_next = DONE;
         DONE: begin
            z_valid    = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc      <= '0;
         term_cnt <= '0;
      end else if (state == IDLE && start) begin
         acc      <= acc_init;
         term_cnt <= '0;
      end else if (accept) begin
         acc      <= acc + {{5{product[16]}}, product};
         term_cnt <= term_cnt + 5'd1;
      end
   end

   // z/sat are only rewritten in SCALE so they stay stable for a late LUT sample.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         z   <= '0;
         sat <= 1'b0;
      end else if (state == SCALE) begin
         if (scaled[21]) begin
            z   <= 8'd0;
            sat <= 1'b1;
         end else if (|scaled[20:8]) begin
            z   <= 8'd255;
            sat <= 1'b1;
         end else begin
            z   <= scaled[7:0];
            sat <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: directed cases plus randomized evaluations against an arithmetic model.
module tb_neuron_mac;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       x_valid = 1'b0;
   logic       x_ready;
   logic [7:0] x = '0;
   logic [7:0] w = '0;
   logic [7:0] z;
   logic       z_valid;
   logic       sat;
   logic       busy;
`ifdef NEURON_MAC_BIAS_EN
   logic [7:0] bias = '0;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int zv_count = 0;

   logic [7:0] tx[N];
   logic [7:0] tw[N];

   neuron_mac #(.N_INPUTS(N)) dut (
      .clk(clk), .resetn(resetn), .start(start), .x_valid(x_valid), .x_ready(x_ready),
      .x(x), .w(w), .z(z), .z_valid(z_valid), .sat(sat), .busy(busy)
`ifdef NEURON_MAC_BIAS_EN
      , .bias(bias)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (z_valid === 1'b1) zv_count++;

   // Reference: exact integer dot product, floor-divided by 16, clamped to a byte.
   task automatic model(input int bias_v, output logic [7:0] ez, output logic esat);
      int sum, s;
      sum = bias_v * 16;
      for (int i = 0; i < N; i++) sum += int'(tx[i]) * int'($signed(tw[i]));
      if (sum >= 0) s = sum / 16;
      else          s = -((-sum + 15) / 16);
      if (s < 0)        begin ez = 8'd0;   esat = 1'b1; end
      else if (s > 255) begin ez = 8'd255; esat = 1'b1; end
      else              begin ez = 8'(s);  esat = 1'b0; end
   endtask

   task automatic fill(input int xv, input int wv);
      for (int i = 0; i < N; i++) begin
         tx[i] = 8'(xv);
         tw[i] = 8'(wv);
      end
   endtask

   task automatic run_eval(input string name, input int gap_lo, input int gap_hi,
                           input bit poke_start, input int bias_v);
      logic [7:0] ez;
      logic       esat;
      int         zv0, gap;
      model(bias_v, ez, esat);
      zv0 = zv_count;
`ifdef NEURON_MAC_BIAS_EN
      bias = 8'(bias_v);
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
`ifdef NEURON_MAC_BIAS_EN
      bias = 8'($urandom_range(0, 255));
`endif
      n_checks++;
      if (busy !== 1'b1 || x_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s enter_acc: busy=%b x_ready=%b, required 1 1", name, busy, x_ready);
      end
      for (int i = 0; i < N; i++) begin
         gap = $urandom_range(gap_lo, gap_hi);
         repeat (gap) begin
            x = 8'($urandom_range(0, 255));
            w = 8'($urandom_range(0, 255));
            if (poke_start) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end
         x = tx[i];
         w = tw[i];
         x_valid = 1'b1;
         @(posedge clk); #1;
         x_valid = 1'b0;
         x = 8'($urandom_range(0, 255));
         w = 8'($urandom_range(0, 255));
      end
      n_checks++;
      if (z_valid !== 1'b0 || busy !== 1'b1 || x_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s scale_cycle: z_valid=%b busy=%b x_ready=%b, required 0 1 0", name, z_valid, busy, x_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (z_valid !== 1'b1 || z !== ez || sat !== esat) begin
         n_fail++;
         $display("FAIL %s result: z_valid=%b z=%0d sat=%b, required 1 %0d %b", name, z_valid, z, sat, ez, esat);
      end
      @(posedge clk); #1;
      n_checks++;
      if (z_valid !== 1'b0 || busy !== 1'b0 || z !== ez || sat !== esat) begin
         n_fail++;
         $display("FAIL %s after_done: z_valid=%b busy=%b z=%0d sat=%b, required 0 0 %0d %b", name, z_valid, busy, z, sat, ez, esat);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (zv_count - zv0 !== 1) begin
         n_fail++;
         $display("FAIL %s zv_pulses: got %0d, required 1", name, zv_count - zv0);
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (z !== 8'd0 || z_valid !== 1'b0 || sat !== 1'b0 || busy !== 1'b0 || x_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: z=%0d z_valid=%b sat=%b busy=%b x_ready=%b, required all 0", z, z_valid, sat, busy, x_ready);
      end
      @(posedge clk); #3;
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      fill(16, 16);
      run_eval("nominal", 0, 0, 1'b0, 0);
      fill(255, -1);
      run_eval("neg_clamp", 0, 0, 1'b0, 0);
      fill(255, 127);
      run_eval("pos_clamp", 0, 0, 1'b0, 0);
      fill(16, 16);
      run_eval("backpressure", 3, 3, 1'b1, 0);
   endtask

   task automatic test_done_start();
      logic [7:0] ez;
      logic       esat;
      fill(20, 3);
      model(0, ez, esat);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         x = tx[i]; w = tw[i]; x_valid = 1'b1;
         @(posedge clk); #1;
      end
      x_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || z !== ez) begin
         n_fail++;
         $display("FAIL done_start_ignored: busy=%b z=%0d, required 0 %0d", busy, z, ez);
      end
      fill(16, 16);
      run_eval("after_done_start", 0, 0, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      int zv0;
      zv0 = zv_count;
      fill(16, 16);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         x = tx[i]; w = tw[i]; x_valid = 1'b1;
         @(posedge clk); #1;
      end
      x_valid = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      n_checks++;
      if (z !== 8'd0 || z_valid !== 1'b0 || sat !== 1'b0 || busy !== 1'b0 || x_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: z=%0d z_valid=%b sat=%b busy=%b x_ready=%b, required all 0", z, z_valid, sat, busy, x_ready);
      end
      @(posedge clk); #3;
      resetn = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (zv_count !== zv0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_abandon: zv_pulses=%0d busy=%b, required 0 0", zv_count - zv0, busy);
      end
      run_eval("after_reset_mid", 0, 0, 1'b0, 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < N; i++) begin
            tx[i] = 8'($urandom_range(0, 255));
            tw[i] = 8'($urandom_range(0, 255));
         end
         run_eval($sformatf("random_%0d", k), 0, 2, k[0], 0);
      end
   endtask

`ifdef NEURON_MAC_BIAS_EN
   task automatic test_bias();
      fill(16, 16);
      run_eval("bias_pos", 0, 0, 1'b0, 10);
      run_eval("bias_neg", 0, 0, 1'b0, -70);
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < N; i++) begin
            tx[i] = 8'($urandom_range(0, 255));
            tw[i] = 8'($urandom_range(0, 255));
         end
         run_eval($sformatf("bias_rand_%0d", k), 0, 1, 1'b0, $urandom_range(0, 255) - 128);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_done_start();
      test_reset_mid();
      test_random();
`ifdef NEURON_MAC_BIAS_EN
      test_bias();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
